keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 500, clk cycles per column dwell (100 MHz / 500 = 200 kHz column rate); set to 5 in simulation.
REQ-002 SHALL have parameter DEBOUNCE, default 4, consecutive agreeing frames needed to accept a press or a release; legal range 1..15.
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz; the only clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port row  input  4  keypad row lines, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port col  output  4  column drive, active-low, exactly one bit low at any time.
REQ-007 SHALL have port key_code  output  4  accepted key, {col_idx[1:0], row_idx[1:0]}.
REQ-008 SHALL have port key_valid  output  1  one-clk pulse when a new key is accepted.
REQ-009 SHALL have port key_held  output  1  high from acceptance until the release is debounced.

Function
REQ-010 SHALL pass row through a 2-flop synchronizer before any use.
REQ-011 SHALL generate a scan tick every SCAN_DIV clk cycles with a counter counting 0..SCAN_DIV-1 and wrapping.
REQ-012 SHALL, on each tick, sample the synchronized row for the current column, then advance col_idx 0->1->2->3->0 with col = ~(1<<col_idx).
REQ-013 SHALL define a frame as the 4 ticks covering col_idx 0..3; frame result is evaluated on the tick that samples col_idx 3.
REQ-014 SHALL classify a frame: NONE (no low row bit), SINGLE (exactly one low bit over all 16 positions, code = col*4+row), MULTI (two or more).
REQ-015 SHALL implement states IDLE, DEBOUNCE, PRESSED, RELEASE; frame results cause transitions only at frame end.
REQ-016 SHALL in IDLE: on SINGLE latch candidate code, set count=1, go DEBOUNCE (if DEBOUNCE==1 accept immediately, go PRESSED); NONE/MULTI stay IDLE.
REQ-017 SHALL in DEBOUNCE: SINGLE with same code increments count; when count reaches DEBOUNCE accept and go PRESSED; a different code, NONE or MULTI go IDLE with count=0.
REQ-018 SHALL on acceptance load key_code with the candidate, pulse key_valid high for exactly the one clk following the frame-end tick, and set key_held=1.
REQ-019 SHALL in PRESSED: NONE sets count=1 and goes RELEASE (or IDLE directly if DEBOUNCE==1); SINGLE or MULTI stay PRESSED; a second key while held never produces key_valid.
REQ-020 SHALL in RELEASE: NONE increments count and on reaching DEBOUNCE clears key_held and goes IDLE; any SINGLE/MULTI returns to PRESSED without a new key_valid.
REQ-021 SHALL hold key_code stable between acceptances, including after release.
REQ-022 SHALL give press latency DEBOUNCE frames (4*SCAN_DIV*DEBOUNCE clk) plus at most one frame of phase plus 3 clk synchronizer/register delay.

Reset
REQ-023 SHALL, while rst=1, force col=4'b1110, col_idx=0, tick counter=0, state=IDLE, count=0, candidate=0, key_code=0, key_valid=0, key_held=0, synchronizer flops=4'b1111.
REQ-024 SHALL, on rst asserted mid-press, drop key_held and key_valid immediately; a key still held after reset release is re-debounced and re-reported.

Structure
REQ-025 SHALL place the state encoding (2-bit IDLE=0, DEBOUNCE=1, PRESSED=2, RELEASE=3) and the frame-class encoding in a shared keypad_pkg include.
REQ-026 SHALL implement the tick divider as sub-module scan_tick (parameter SCAN_DIV; ports clk, rst, tick); the rest stays in keypad_scan.

Verification (SCAN_DIV=5, DEBOUNCE=4)
REQ-027 SHALL cover: reset release, no key -> col cycles 1110,1101,1011,0111 every 5 clk; key_valid never asserts.
REQ-028 SHALL cover: key at col 2 row 1 held 6 frames -> one key_valid pulse, key_code=4'h9, key_held=1, pulse within 4–5 frames plus 3 clk of press.
REQ-029 SHALL cover: press with 1-frame bounce gaps before 4 clean frames -> key_valid only after 4 consecutive matching frames, exactly once.
REQ-030 SHALL cover: keys 0x3 and 0xC pressed together -> MULTI, no key_valid; release 0xC -> 0x3 accepted after 4 frames.
REQ-031 SHALL cover: key 0x5 held, release for 2 frames then re-press -> key_held stays 1, no second key_valid; full release 4 frames -> key_held=0.
REQ-032 SHALL cover: rst pulsed while key 0x7 held -> outputs zero asynchronously; after rst release, key_valid with 0x7 after 4 frames.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared encodings for the keypad scanner: FSM states, frame classes and
// small helpers that reduce one column's row sample.
package keypad_pkg;

    // FSM state encoding (2 bits)
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    // Frame classification over all 16 key positions
    localparam logic [1:0] FR_NONE   = 2'd0;
    localparam logic [1:0] FR_SINGLE = 2'd1;
    localparam logic [1:0] FR_MULTI  = 2'd2;

    // Number of asserted bits in a 4-bit active-high row vector.
    function automatic logic [2:0] count_low(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Index of the lowest asserted bit; only meaningful when v != 0.
    function automatic logic [1:0] first_low(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Column dwell divider: one-clock tick every SCAN_DIV clocks, counter
// runs 0..SCAN_DIV-1 and wraps.
module scan_tick #(
    parameter int SCAN_DIV = 500
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap to zero after the last dwell clock
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // Divider counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner. Drives one active-low column per dwell,
// collects the synchronized rows into a frame, classifies the frame as
// NONE/SINGLE/MULTI and debounces presses and releases frame by frame.
//
// Output handshake: key_valid is a one-clock strobe, qualified by nothing
// else; key_code is valid whenever key_valid is high and holds its value
// until the next strobe. There is no back-pressure.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 500,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [1:0] dbg_state_o
);

    localparam logic [3:0] DEB_C = 4'(DEBOUNCE);

    logic       tick;
    logic [3:0] row_s1_q, row_s2_q;
    logic [1:0] col_idx_q, col_idx_d;
    logic [1:0] acc_cnt_q, acc_cnt_d;
    logic [3:0] acc_code_q, acc_code_d;
    logic [1:0] state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d;
    logic       key_held_q, key_held_d;

    logic [3:0] row_low;
    logic [2:0] col_cnt;
    logic [3:0] sum_cnt;
    logic [1:0] sat_cnt;
    logic [3:0] samp_code;
    logic       frame_end;
    logic [1:0] frame_cls;
    logic [3:0] count_inc;

    scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchronizer for the asynchronous row lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1_q <= 4'b1111;
            row_s2_q <= 4'b1111;
        end else begin
            row_s1_q <= row;
            row_s2_q <= row_s1_q;
        end
    end

    // Reduce this column's sample and merge it with the frame so far;
    // the population saturates at 2 because MULTI needs no finer count
    always_comb begin
        row_low   = ~row_s2_q;
        col_cnt   = count_low(row_low);
        sum_cnt   = {2'b00, acc_cnt_q} + {1'b0, col_cnt};
        sat_cnt   = (sum_cnt >= 4'd2) ? 2'd2 : sum_cnt[1:0];
        samp_code = (acc_cnt_q == 2'd0) ? {col_idx_q, first_low(row_low)} : acc_code_q;
        frame_end = tick && (col_idx_q == 2'd3);
        case (sat_cnt)
            2'd0:    frame_cls = FR_NONE;
            2'd1:    frame_cls = FR_SINGLE;
            default: frame_cls = FR_MULTI;
        endcase
    end

    // Column advance and frame accumulator next-state
    always_comb begin
        col_idx_d  = col_idx_q;
        acc_cnt_d  = acc_cnt_q;
        acc_code_d = acc_code_q;
        if (tick) begin
            col_idx_d = col_idx_q + 2'd1;
            if (frame_end) begin
                acc_cnt_d  = 2'd0;
                acc_code_d = 4'd0;
            end else begin
                acc_cnt_d  = sat_cnt;
                acc_code_d = samp_code;
            end
        end
    end

    // Scan position and frame accumulator registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_idx_q  <= 2'd0;
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'd0;
        end else begin
            col_idx_q  <= col_idx_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
        end
    end

    // Debounce FSM: only a frame end can move it
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        count_inc   = count_q + 4'd1;
        if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_cls == FR_SINGLE) begin
                        cand_d  = samp_code;
                        count_d = 4'd1;
                        if (DEB_C == 4'd1) begin
                            key_code_d  = samp_code;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            state_d     = ST_PRESSED;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (frame_cls == FR_SINGLE && samp_code == cand_q) begin
                        count_d = count_inc;
                        if (count_inc == DEB_C) begin
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            state_d     = ST_PRESSED;
                        end
                    end else begin
                        count_d = 4'd0;
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    // Extra keys while held are ignored until a clean release
                    if (frame_cls == FR_NONE) begin
                        if (DEB_C == 4'd1) begin
                            count_d    = 4'd0;
                            key_held_d = 1'b0;
                            state_d    = ST_IDLE;
                        end else begin
                            count_d = 4'd1;
                            state_d = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (frame_cls == FR_NONE) begin
                        count_d = count_inc;
                        if (count_inc == DEB_C) begin
                            count_d    = 4'd0;
                            key_held_d = 1'b0;
                            state_d    = ST_IDLE;
                        end
                    end else begin
                        count_d = 4'd0;
                        state_d = ST_PRESSED;
                    end
                end
                default: begin
                    count_d = 4'd0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= 4'd0;
            cand_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col         = ~(4'b0001 << col_idx_q);
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_held    = key_held_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad model drives rows from the column
// strobes, stimulus is applied one whole frame at a time, and a
// frame-level reference model predicts accepted keys and the held flag.
module tb_keypad_scan;

    localparam int SCAN_DIV = 5;
    localparam int DEB      = 4;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [1:0]  dbg_state;

    logic [15:0] keys;          // bit n set = key with code n pressed
    logic [3:0]  exp_q[$];
    int          total;
    int          bad;
    int          cyc;
    int          last_valid_cyc;

    // Reference model state
    bit          m_held;
    int          m_streak;
    logic [3:0]  m_cand;
    logic [3:0]  m_last;

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB)) dut (
        .clk         (clk),
        .rst         (rst),
        .row         (row),
        .col         (col),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held),
        .dbg_state_o (dbg_state)
    );

    // Clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Keypad matrix: a row reads low if a pressed key sits on a driven column
    always_comb begin
        row = 4'b1111;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col[c] && keys[c*4+r]) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: debounce by run lengths of identical frames
    task automatic model_frame(input logic [15:0] k);
        int n;
        logic [3:0] code;
        n = $countones(k);
        code = 4'd0;
        for (int i = 0; i < 16; i++) if (k[i]) code = 4'(i);
        if (!m_held) begin
            if (n == 1) begin
                if (m_streak == 0) begin
                    m_cand   = code;
                    m_streak = 1;
                end else if (code == m_cand) begin
                    m_streak++;
                end else begin
                    m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
            if (m_streak == DEB) begin
                exp_q.push_back(m_cand);
                m_last   = m_cand;
                m_held   = 1'b1;
                m_streak = 0;
            end
        end else begin
            if (n == 0) m_streak++;
            else        m_streak = 0;
            if (m_streak == DEB) begin
                m_held   = 1'b0;
                m_streak = 0;
            end
        end
    endtask

    // Wait (bounded) for the column sequence to return to column 0
    task automatic wait_frame_start();
        logic [3:0] prev;
        int n;
        bit found;
        prev = col;
        n = 0;
        found = 1'b0;
        while (!found && n < 10 * FRAME) begin
            @(negedge clk);
            n++;
            if (col == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = col;
        end
        if (!found) check("frame_start_timeout", 32'd0, 32'd1);
    endtask

    // Frame boundary: check held against the model, then apply the next frame
    task automatic run_frame(input logic [15:0] k);
        wait_frame_start();
        check("key_held", 32'(key_held), 32'(m_held));
        keys = k;
        model_frame(k);
    endtask

    task automatic run_frames(input logic [15:0] k, input int n);
        for (int i = 0; i < n; i++) run_frame(k);
    endtask

    task automatic do_reset(input int hold_cycles);
        check("pending_before_reset", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        rst = 1'b1;
        #1;
        check("rst_col", 32'(col), 32'hE);
        check("rst_key_code", 32'(key_code), 32'h0);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_held", 32'(key_held), 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        repeat (hold_cycles) @(negedge clk);
        m_held = 1'b0; m_streak = 0; m_cand = 4'd0; m_last = 4'd0;
        rst = 1'b0;
        // The frame starting at reset release sees the current keys
        model_frame(keys);
    endtask

    // Monitor / scoreboard: pop an expectation on every key_valid
    always @(negedge clk) begin
        if (!rst && key_valid) begin
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_key_valid", 32'(key_code), 32'hFFFF);
            end else begin
                check("key_code", 32'(key_code), 32'(exp_q.pop_front()));
                check("held_with_valid", 32'(key_held), 32'd1);
            end
        end
    end

    initial begin
        int press_cyc;
        logic [15:0] cur;
        int r;
        total = 0; bad = 0; cyc = 0; last_valid_cyc = 0;
        keys = 16'h0;
        m_held = 1'b0; m_streak = 0; m_cand = 4'd0; m_last = 4'd0;
        rst = 1'b1;
        @(negedge clk);
        do_reset(3);

        // Idle scan: walk the columns every SCAN_DIV clocks
        wait_frame_start();
        for (int i = 0; i < 2 * FRAME; i++) begin
            logic [3:0] exp_col;
            exp_col = ~(4'b0001 << ((i / SCAN_DIV) % 4));
            check("col_walk", 32'(col), 32'(exp_col));
            if (i != 2 * FRAME - 1) @(negedge clk);
        end
        run_frames(16'h0, 2);

        // Key 0x9 held 6 frames: one pulse with bounded latency
        wait_frame_start();
        keys = 16'h0200;
        model_frame(keys);
        press_cyc = cyc;
        run_frames(16'h0200, 5);
        check("press_latency_ok",
              32'((last_valid_cyc - press_cyc) >= 4 * FRAME - 3 &&
                  (last_valid_cyc - press_cyc) <= 5 * FRAME + 3), 32'd1);
        run_frames(16'h0, DEB + 1);
        check("code_after_release", 32'(key_code), 32'h9);

        // Bounce gaps before four clean frames
        run_frame(16'h0200); run_frame(16'h0);
        run_frame(16'h0200); run_frame(16'h0);
        run_frames(16'h0200, 5);
        run_frames(16'h0, DEB + 1);

        // 0x3 and 0xC together, then 0xC released
        run_frames(16'h1008, 3);
        run_frames(16'h0008, 5);
        run_frames(16'h0, DEB + 1);
        check("code_after_multi", 32'(key_code), 32'h3);

        // 0x5 held, short release, re-press, full release
        run_frames(16'h0020, 5);
        run_frames(16'h0, 2);
        run_frames(16'h0020, 2);
        run_frames(16'h0, DEB + 1);
        check("code_stable_0x5", 32'(key_code), 32'h5);

        // Reset while 0x7 is held, key stays down through reset
        run_frames(16'h0080, 6);
        repeat (7) @(negedge clk);
        do_reset(3);
        run_frames(16'h0080, 5);
        run_frames(16'h0, DEB + 1);

        // Randomized frame sequences
        cur = 16'h0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) >= 7) begin
                r = $urandom_range(0, 9);
                if (r < 3)      cur = 16'h0;
                else if (r < 8) cur = 16'h1 << $urandom_range(0, 15);
                else            cur = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            end
            run_frame(cur);
        end
        run_frames(16'h0, DEB + 1);
        run_frame(16'h0);
        check("code_final", 32'(key_code), 32'(m_last));
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
